// File: rtl/mux_rr_scheduler.sv
// -----------------------------------------------------------------------------
// mux_rr_scheduler
//
// Round-robin scheduler that time-shares the 8:1 select mux among eight
// requesters. One requester is granted at a time, for a programmable number of
// cycles. The mux uses a reversed mapping: select value 7-k routes input k.
//
// Ports:
//   clk         - rising-edge clock
//   rst_n       - asynchronous active-low reset
//   en_i        - scheduler enable; low blocks new grants and aborts the
//                 current one
//   req_i       - request vector, bit k asks for mux input k
//   hold_len_i  - grant length in cycles, sampled when the grant is issued
//                 (0 is treated as 1)
//   sel_o       - registered mux select, 7-k while requester k is granted;
//                 keeps its last value when no grant is active
//   gnt_o       - registered one-hot grant
//   busy_o      - high while a grant is being held
//   done_o      - one-cycle pulse in the cycle after a grant ends
// -----------------------------------------------------------------------------
module mux_rr_scheduler #(
    parameter int HOLD_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [7:0]        req_i,
    input  logic [HOLD_W-1:0] hold_len_i,
    output logic [2:0]        sel_o,
    output logic [7:0]        gnt_o,
    output logic              busy_o,
    output logic              done_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [HOLD_W-1:0] CNT_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] CNT_ZERO = HOLD_W'(0);

    state_t            state_q, state_d;
    logic [2:0]        last_q,  last_d;
    logic [HOLD_W-1:0] cnt_q,   cnt_d;
    logic [2:0]        sel_q,   sel_d;
    logic [7:0]        gnt_q,   gnt_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    logic [2:0]        winner_s;
    logic              found_s;
    logic [2:0]        idx_s;
    logic [HOLD_W-1:0] hold_eff_s;

    // Round-robin search starting just above the last served index.
    // The loop walks from the farthest candidate to the nearest so the nearest
    // requesting index overwrites the others; offset 8 wraps to last_q itself,
    // giving the requester just served the lowest priority.
    always_comb begin
        winner_s = 3'd0;
        found_s  = 1'b0;
        idx_s    = 3'd0;
        for (int i = 8; i >= 1; i--) begin
            idx_s = last_q + 3'(i);
            if (req_i[idx_s]) begin
                winner_s = idx_s;
                found_s  = 1'b1;
            end else begin
                winner_s = winner_s;
            end
        end
    end

    // A zero hold length still yields a one-cycle grant.
    always_comb begin
        if (hold_len_i == CNT_ZERO) begin
            hold_eff_s = CNT_ONE;
        end else begin
            hold_eff_s = hold_len_i;
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                gnt_d  = 8'h00;
                busy_d = 1'b0;
                if (en_i && found_s) begin
                    state_d = HOLD;
                    gnt_d   = 8'h01 << winner_s;
                    sel_d   = 3'd7 - winner_s;
                    last_d  = winner_s;
                    cnt_d   = hold_eff_s;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                // last_q holds the index of the requester currently granted.
                if ((cnt_q == CNT_ONE) || !req_i[last_q] || !en_i) begin
                    state_d = IDLE;
                    gnt_d   = 8'h00;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 8'h00;
                busy_d  = 1'b0;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 3'd7;
            cnt_q   <= CNT_ZERO;
            sel_q   <= 3'd0;
            gnt_q   <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sel_o  = sel_q;
    assign gnt_o  = gnt_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_scheduler
//
// Directed testbench for mux_rr_scheduler. Inputs change and outputs are
// sampled 1 time unit after each rising edge; expected values are written out
// by hand from the scheduler's intended behaviour.
// -----------------------------------------------------------------------------
module tb_mux_rr_scheduler;

    logic       clk;
    logic       rst_n;
    logic       en_i;
    logic [7:0] req_i;
    logic [3:0] hold_len_i;
    logic [2:0] sel_o;
    logic [7:0] gnt_o;
    logic       busy_o;
    logic       done_o;

    int n_checks;
    int n_errors;

    mux_rr_scheduler #(.HOLD_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en_i       (en_i),
        .req_i      (req_i),
        .hold_len_i (hold_len_i),
        .sel_o      (sel_o),
        .gnt_o      (gnt_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    // 10-unit clock period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [7:0] g, input logic [2:0] s,
                             input logic b, input logic d);
        check_eq({tag, ".gnt"},  {24'd0, gnt_o},  {24'd0, g});
        check_eq({tag, ".sel"},  {29'd0, sel_o},  {29'd0, s});
        check_eq({tag, ".busy"}, {31'd0, busy_o}, {31'd0, b});
        check_eq({tag, ".done"}, {31'd0, done_o}, {31'd0, d});
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        en_i       = 1'b0;
        req_i      = 8'h00;
        hold_len_i = 4'd0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Reset state
        do_reset();
        check_out("reset", 8'h00, 3'd0, 1'b0, 1'b0);

        // T1: single requester 2, hold_len 3; hold_len change mid-grant ignored
        en_i = 1'b1; req_i = 8'h04; hold_len_i = 4'd3;
        tick(); check_out("t1_c1", 8'h04, 3'd5, 1'b1, 1'b0);
        hold_len_i = 4'd15;
        tick(); check_out("t1_c2", 8'h04, 3'd5, 1'b1, 1'b0);
        tick(); check_out("t1_c3", 8'h04, 3'd5, 1'b1, 1'b0);
        tick(); check_out("t1_end", 8'h00, 3'd5, 1'b0, 1'b1);
        req_i = 8'h00;
        tick(); check_out("t1_idle", 8'h00, 3'd5, 1'b0, 1'b0);

        // T2: all requesting, hold_len 1 -> 0..7,0 with a done gap between
        do_reset();
        en_i = 1'b1; req_i = 8'hFF; hold_len_i = 4'd1;
        for (int k = 0; k < 9; k++) begin
            logic [2:0] kk;
            kk = 3'(k);
            tick(); check_out($sformatf("t2_g%0d", k), 8'h01 << kk, 3'd7 - kk, 1'b1, 1'b0);
            tick(); check_out($sformatf("t2_gap%0d", k), 8'h00, 3'd7 - kk, 1'b0, 1'b1);
        end
        req_i = 8'h00;
        tick(); check_out("t2_idle", 8'h00, 3'd7, 1'b0, 1'b0);

        // T3: requester 2 with hold_len 10 withdraws on grant cycle 4
        do_reset();
        en_i = 1'b1; req_i = 8'h04; hold_len_i = 4'd10;
        tick(); check_out("t3_c1", 8'h04, 3'd5, 1'b1, 1'b0);
        req_i = 8'h45;   // new requests during HOLD are not sampled yet
        tick(); check_out("t3_c2", 8'h04, 3'd5, 1'b1, 1'b0);
        tick(); check_out("t3_c3", 8'h04, 3'd5, 1'b1, 1'b0);
        tick(); check_out("t3_c4", 8'h04, 3'd5, 1'b1, 1'b0);
        req_i = 8'h41;
        tick(); check_out("t3_end", 8'h00, 3'd5, 1'b0, 1'b1);
        tick(); check_out("t3_next", 8'h40, 3'd1, 1'b1, 1'b0);
        req_i = 8'h00;
        tick(); check_out("t3_wd", 8'h00, 3'd1, 1'b0, 1'b1);

        // T4: hold_len 0 on requester 7 gives a one-cycle grant
        do_reset();
        en_i = 1'b1; req_i = 8'h80; hold_len_i = 4'd0;
        tick(); check_out("t4_g", 8'h80, 3'd0, 1'b1, 1'b0);
        tick(); check_out("t4_end", 8'h00, 3'd0, 1'b0, 1'b1);
        req_i = 8'h00;
        tick(); check_out("t4_idle", 8'h00, 3'd0, 1'b0, 1'b0);

        // T5: asynchronous reset in the middle of a grant to requester 5
        do_reset();
        en_i = 1'b1; req_i = 8'h20; hold_len_i = 4'd8;
        tick(); check_out("t5_c1", 8'h20, 3'd2, 1'b1, 1'b0);
        tick(); check_out("t5_c2", 8'h20, 3'd2, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("t5_arst", 8'h00, 3'd0, 1'b0, 1'b0);
        req_i = 8'h21; hold_len_i = 4'd1;
        tick(); check_out("t5_inrst", 8'h00, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(); check_out("t5_first", 8'h01, 3'd7, 1'b1, 1'b0);
        req_i = 8'h00;
        tick(); check_out("t5_end", 8'h00, 3'd7, 1'b0, 1'b1);

        // T6: enable gating and abort on enable drop
        do_reset();
        en_i = 1'b0; req_i = 8'h10; hold_len_i = 4'd4;
        tick(); check_out("t6_off1", 8'h00, 3'd0, 1'b0, 1'b0);
        tick(); check_out("t6_off2", 8'h00, 3'd0, 1'b0, 1'b0);
        en_i = 1'b1;
        tick(); check_out("t6_c1", 8'h10, 3'd3, 1'b1, 1'b0);
        tick(); check_out("t6_c2", 8'h10, 3'd3, 1'b1, 1'b0);
        en_i = 1'b0;
        tick(); check_out("t6_end", 8'h00, 3'd3, 1'b0, 1'b1);
        tick(); check_out("t6_idle", 8'h00, 3'd3, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
